// File: rtl/msk_ascon_sbox_layer.sv
// Masked Ascon constant-addition + S-box layer, d-share DOM-indep, 320-bit state.
// Latency: 1 cycle; registers hold the pre-layer lanes and the DOM AND terms.
// Backpressure: result held while out_ready=0; in_ready = !out_valid || out_ready.
module msk_ascon_sbox_layer #(
    parameter  int d        = 2,
    localparam int W        = 64,
    localparam int P        = d * (d - 1) / 2,
    localparam int RND_BITS = 5 * W * P
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [5*W*d-1:0]    in_state,
    input  logic [7:0]          in_rc,
    input  logic [RND_BITS-1:0] rnd,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [5*W*d-1:0]    out_state
);
    typedef logic [W-1:0][d-1:0]        lane_t;
    typedef logic [W-1:0][d-1:0][d-1:0] term_lane_t;

    // Pairs (j<k) enumerated lexicographically: (0,1),(0,2),...,(1,2),...
    function automatic int pair_idx(input int j, input int k);
        return j * d - (j * (j + 1)) / 2 + (k - j - 1);
    endfunction

    lane_t      [4:0]            in_lanes;
    lane_t      [4:0]            cst;
    lane_t      [4:0]            pre;
    lane_t      [4:0]            a_q;
    lane_t      [4:0]            t;
    lane_t      [4:0]            y;
    lane_t      [4:0]            x;
    term_lane_t [4:0]            term_d;
    term_lane_t [4:0]            term_q;
    logic       [4:0][W-1:0][P-1:0] rnd_v;
    logic                        load;

    assign {in_lanes[0], in_lanes[1], in_lanes[2], in_lanes[3], in_lanes[4]} = in_state;
    assign rnd_v    = rnd;
    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;

    // Round constant goes into share 0 of x2 only, then the per-share linear pre-layer.
    always_comb begin
        cst = in_lanes;
        for (int k = 0; k < 8; k++) begin
            cst[2][k][0] = in_lanes[2][k][0] ^ in_rc[k];
        end
        pre[0] = cst[0] ^ cst[4];
        pre[1] = cst[1];
        pre[2] = cst[2] ^ cst[1];
        pre[3] = cst[3];
        pre[4] = cst[4] ^ cst[3];
    end

    // DOM-indep partial products: a is (~a_r) via share-0 inversion, b is a_{r+1}.
    // Cross terms are blinded with the shared r_jk before they reach a register.
    always_comb begin
        term_d = '0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < d; j++) begin
                    for (int k = 0; k < d; k++) begin
                        term_d[r][i][j][k] = (pre[r][i][j] ^ (j == 0))
                                           & pre[(r + 1) % 5][i][k];
                        if (k > j) begin
                            term_d[r][i][j][k] = term_d[r][i][j][k]
                                               ^ rnd_v[r][i][pair_idx(j, k)];
                        end else if (k < j) begin
                            term_d[r][i][j][k] = term_d[r][i][j][k]
                                               ^ rnd_v[r][i][pair_idx(k, j)];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            term_q    <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                a_q    <= pre;
                term_q <= term_d;
            end
            if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    // Share j of each AND result compresses its own row of registered terms.
    always_comb begin
        t = '0;
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < W; i++) begin
                for (int j = 0; j < d; j++) begin
                    t[r][i][j] = ^term_q[r][i][j];
                end
            end
        end
        for (int r = 0; r < 5; r++) begin
            y[r] = a_q[r] ^ t[(r + 1) % 5];
        end
        x[0] = y[0] ^ y[4];
        x[1] = y[1] ^ y[0];
        x[2] = y[2];
        x[3] = y[3] ^ y[2];
        x[4] = y[4];
        for (int i = 0; i < W; i++) begin
            x[2][i][0] = ~y[2][i][0];
        end
    end

    assign out_state = {x[0], x[1], x[2], x[3], x[4]};

endmodule
